// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing the single-port maze cell memory between the rat-solver (port 0)
// and the path-replay unit (port 1). Define ARB_STATS_EN to add per-port completion counters.
module maze_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              mem_cen,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       gcnt0,
    output logic [15:0]       gcnt1
`endif
);
    localparam int               CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_CAP = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {ARB, ACCESS, RDATA} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic              hold_q, hold_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              mem_cen_q, mem_cen_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              win;
    logic              hold_ok;
    logic              other_req;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        hold_d     = hold_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack_d      = 2'b00;
        mem_cen_d  = 1'b0;
        mem_wr_d   = 1'b0;
        mem_rd_d   = 1'b0;
        rd_valid_d = 1'b0;
        win        = 1'b0;
        other_req  = req[!last_gnt_q];
        // The previous owner keeps the memory only while it still asks and the cap is not hit.
        hold_ok    = hold_q && req[last_gnt_q] && (lock_cnt_q < LOCK_CAP);

        unique case (state_q)
            ARB: begin
                if (!req[last_gnt_q]) hold_d = 1'b0;
                if (req != 2'b00) begin
                    if (hold_ok) begin
                        win        = last_gnt_q;
                        lock_cnt_d = other_req ? lock_cnt_q + 1'b1 : '0;
                    end else begin
                        win        = (req == 2'b11) ? !last_gnt_q : req[1];
                        lock_cnt_d = '0;
                    end
                    owner_d    = win;
                    mem_addr_d = win ? addr1 : addr0;
                    mem_din_d  = win ? wdata1 : wdata0;
                    mem_cen_d  = 1'b1;
                    mem_wr_d   = we[win];
                    mem_rd_d   = !we[win];
                    ack_d      = we[win] ? {win, !win} : 2'b00;
                    gnt_d      = {win, !win};
                    busy_d     = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_wr_q) begin
                    last_gnt_d = owner_q;
                    hold_d     = lock[owner_q];
                    gnt_d      = 2'b00;
                    busy_d     = 1'b0;
                    state_d    = ARB;
                end else begin
                    ack_d      = {owner_q, !owner_q};
                    rd_valid_d = 1'b1;
                    state_d    = RDATA;
                end
            end
            RDATA: begin
                last_gnt_d = owner_q;
                hold_d     = lock[owner_q];
                gnt_d      = 2'b00;
                busy_d     = 1'b0;
                state_d    = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            hold_q     <= 1'b0;
            lock_cnt_q <= '0;
            ack_q      <= 2'b00;
            gnt_q      <= 2'b00;
            busy_q     <= 1'b0;
            mem_cen_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            hold_q     <= hold_d;
            lock_cnt_q <= lock_cnt_d;
            ack_q      <= ack_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            mem_cen_q  <= mem_cen_d;
            mem_wr_q   <= mem_wr_d;
            mem_rd_q   <= mem_rd_d;
            rd_valid_q <= rd_valid_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign ack      = ack_q;
    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign mem_cen  = mem_cen_q;
    assign mem_wr   = mem_wr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    // Memory read data arrives during RDATA; it is forwarded only while the read ack is up.
    assign rdata    = rd_valid_q ? mem_dout : '0;

`ifdef ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt0_d;
    logic [15:0] gcnt1_q, gcnt1_d;

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (stat_clr) begin
            gcnt0_d = '0;
            gcnt1_d = '0;
        end else begin
            if (ack_q[0] && (gcnt0_q != 16'hFFFF)) gcnt0_d = gcnt0_q + 16'd1;
            if (ack_q[1] && (gcnt1_q != 16'hFFFF)) gcnt1_d = gcnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter: a scoreboard of expected acks/read data, a behavioural
// synchronous memory, and cycle-exact checks of latency, arbitration order, lock cap and reset.
module tb_maze_mem_arbiter;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 1;
    localparam int LOCK_MAX = 4;

    typedef struct packed {
        logic              port;
        logic              is_rd;
        logic [DATA_W-1:0] rd;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0]        lock;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        gnt;
    logic              busy;
    logic              mem_cen;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
`ifdef ARB_STATS_EN
    logic              stat_clr;
    logic [15:0]       gcnt0;
    logic [15:0]       gcnt1;
`endif

    int                checks   = 0;
    int                failures = 0;
    exp_t              sb[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] mem [256];

    maze_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .lock    (lock),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ack     (ack),
        .rdata   (rdata),
        .gnt     (gnt),
        .busy    (busy),
        .mem_cen (mem_cen),
        .mem_wr  (mem_wr),
        .mem_rd  (mem_rd),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_dout(mem_dout)
`ifdef ARB_STATS_EN
        ,
        .stat_clr(stat_clr),
        .gcnt0   (gcnt0),
        .gcnt1   (gcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears the cycle after the mem_rd cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h23] = 1'b1;
        mem_dout   = '0;
        forever begin
            @(posedge clk);
            if (mem_cen && mem_wr) mem[mem_addr] <= mem_din;
            if (mem_cen && mem_rd) mem_dout <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench did not finish in time");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        assert (obs === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expected);
        end
    endtask

    // Waits (bounded) for ack[p] and checks the number of negedges it took.
    task automatic wait_ack(input logic p, input int max_cyc, input int exp_n, input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (ack[p]) begin
                n = i;
                break;
            end
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        req  = 2'b00;
        we   = 2'b00;
        lock = 2'b00;
        @(negedge clk);
        rst  = 1'b1;
    endtask

    // Scoreboard and protocol invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("inv_wr_rd_excl", 32'(mem_wr & mem_rd), 32'd0);
            check("inv_strobe_cen", 32'((mem_wr | mem_rd) & !mem_cen), 32'd0);
            check("inv_ack_owner", 32'(ack & ~gnt), 32'd0);
            if (ack != 2'b00) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_ack_port", 32'(ack), mon_e.port ? 32'd2 : 32'd1);
                    if (mon_e.is_rd) check("sb_rdata", 32'(rdata), 32'(mon_e.rd));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[8'h23] = 1'b1;
        rst    = 1'b1;
        req    = 2'b00;
        we     = 2'b00;
        lock   = 2'b00;
        addr0  = '0;
        addr1  = '0;
        wdata0 = '0;
        wdata1 = '0;
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        #2 rst = 1'b0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_pins", 32'({mem_cen, mem_wr, mem_rd, mem_addr, mem_din}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
`ifdef ARB_STATS_EN
        check("rst_gcnt", 32'({gcnt0, gcnt1}), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single read on port 0.
        req   = 2'b01;
        we    = 2'b00;
        addr0 = 8'h23;
        sb.push_back('{port: 1'b0, is_rd: 1'b1, rd: ref_mem[8'h23]});
        @(negedge clk);
        check("rd_access_busy", 32'(busy), 32'd1);
        check("rd_access_strobes", 32'({mem_cen, mem_wr, mem_rd}), 32'b101);
        check("rd_access_addr", 32'(mem_addr), 32'h23);
        check("rd_access_gnt", 32'(gnt), 32'd1);
        check("rd_access_ack", 32'(ack), 32'd0);
        @(negedge clk);
        check("rd_rdata_ack", 32'(ack), 32'd1);
        check("rd_rdata_val", 32'(rdata), 32'd1);
        check("rd_rdata_busy", 32'(busy), 32'd1);
        check("rd_rdata_cen", 32'(mem_cen), 32'd0);
        req = 2'b00;
        @(negedge clk);
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_idle_gnt", 32'(gnt), 32'd0);

        // Single write on port 1, then read it back through port 0.
        req    = 2'b10;
        we     = 2'b10;
        addr1  = 8'h5A;
        wdata1 = 1'b1;
        ref_mem[8'h5A] = 1'b1;
        sb.push_back('{port: 1'b1, is_rd: 1'b0, rd: '0});
        @(negedge clk);
        check("wr_strobes", 32'({mem_cen, mem_wr, mem_rd}), 32'b110);
        check("wr_addr", 32'(mem_addr), 32'h5A);
        check("wr_din", 32'(mem_din), 32'd1);
        check("wr_ack", 32'(ack), 32'd2);
        check("wr_gnt", 32'(gnt), 32'd2);
        req = 2'b00;
        @(negedge clk);
        check("wr_idle_busy", 32'(busy), 32'd0);
        req   = 2'b01;
        we    = 2'b00;
        addr0 = 8'h5A;
        sb.push_back('{port: 1'b0, is_rd: 1'b1, rd: ref_mem[8'h5A]});
        wait_ack(1'b0, 10, 2, "readback_latency");
        req = 2'b00;
        @(negedge clk);

        // Simultaneous reads from reset: port 0 first, then strict alternation.
        do_reset();
        req   = 2'b11;
        we    = 2'b00;
        addr0 = 8'h23;
        addr1 = 8'h40;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{port: 1'b0, is_rd: 1'b1, rd: ref_mem[8'h23]});
            sb.push_back('{port: 1'b1, is_rd: 1'b1, rd: ref_mem[8'h40]});
        end
        wait_ack(1'b0, 10, 2, "contend_first_p0");
        wait_ack(1'b1, 10, 3, "contend_then_p1");
        wait_ack(1'b0, 10, 3, "contend_alt_p0");
        wait_ack(1'b1, 10, 3, "contend_alt_p1");
        req = 2'b00;
        @(negedge clk);

        // Locked write burst on port 0 against a continuously requesting port 1.
        do_reset();
        req    = 2'b11;
        we     = 2'b01;
        lock   = 2'b01;
        addr0  = 8'h10;
        wdata0 = 1'b0;
        addr1  = 8'h23;
        for (int i = 0; i < LOCK_MAX + 1; i++) sb.push_back('{port: 1'b0, is_rd: 1'b0, rd: '0});
        sb.push_back('{port: 1'b1, is_rd: 1'b1, rd: ref_mem[8'h23]});
        sb.push_back('{port: 1'b0, is_rd: 1'b0, rd: '0});
        for (int i = 0; i < LOCK_MAX + 1; i++) begin
            ref_mem[8'h10 + i] = 1'(i);
            wait_ack(1'b0, 10, (i == 0) ? 1 : 2, "lock_hold_grant");
            addr0  = 8'h10 + 8'(i + 1);
            wdata0 = 1'(i + 1);
        end
        ref_mem[8'h15] = 1'b1;
        wait_ack(1'b1, 10, 3, "lock_cap_release");
        req = 2'b01;
        wait_ack(1'b0, 10, 2, "lock_after_release");
        req  = 2'b00;
        lock = 2'b00;
        @(negedge clk);
        req   = 2'b10;
        we    = 2'b00;
        addr1 = 8'h15;
        sb.push_back('{port: 1'b1, is_rd: 1'b1, rd: ref_mem[8'h15]});
        wait_ack(1'b1, 10, 2, "lock_data_readback");
        req = 2'b00;
        @(negedge clk);

        // Reset asserted during RDATA: no ack, outputs cleared at once, pending req served after.
        req   = 2'b01;
        we    = 2'b00;
        addr0 = 8'h23;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_gnt_busy", 32'({gnt, busy}), 32'd0);
        check("midrst_mem_pins", 32'({mem_cen, mem_wr, mem_rd, mem_addr, mem_din}), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{port: 1'b0, is_rd: 1'b1, rd: ref_mem[8'h23]});
        wait_ack(1'b0, 10, 2, "post_reset_read");
        req = 2'b00;
        @(negedge clk);

`ifdef ARB_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_clr_initial", 32'({gcnt0, gcnt1}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            req    = 2'b01;
            we     = 2'b01;
            addr0  = 8'h30 + 8'(i);
            wdata0 = 1'b1;
            ref_mem[8'h30 + i] = 1'b1;
            sb.push_back('{port: 1'b0, is_rd: 1'b0, rd: '0});
            wait_ack(1'b0, 10, 1, "stat_p0_write");
            req = 2'b00;
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            req   = 2'b10;
            we    = 2'b00;
            addr1 = 8'h23;
            sb.push_back('{port: 1'b1, is_rd: 1'b1, rd: ref_mem[8'h23]});
            wait_ack(1'b1, 10, 2, "stat_p1_read");
            req = 2'b00;
            @(negedge clk);
        end
        check("stat_gcnt0", 32'(gcnt0), 32'd3);
        check("stat_gcnt1", 32'(gcnt1), 32'd2);
        req    = 2'b01;
        we     = 2'b01;
        addr0  = 8'h33;
        wdata0 = 1'b0;
        sb.push_back('{port: 1'b0, is_rd: 1'b0, rd: '0});
        wait_ack(1'b0, 10, 1, "stat_clr_vs_ack");
        stat_clr = 1'b1;
        req      = 2'b00;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_clr_priority_gcnt0", 32'(gcnt0), 32'd0);
        check("stat_clr_priority_gcnt1", 32'(gcnt1), 32'd0);
`endif

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
- Shares the single-port maze cell memory between two requesters: port 0 = rat-solver controller, port 1 = path-replay/display unit.
- Serialises their read/write transactions with round-robin arbitration, a bounded lock for read-modify-write sequences, and a req/ack handshake.
- Sits between the controllers and the memory; it owns the memory's cen/WR/RD/address/data-in pins.

Parameters:
- ADDR_W, 8, memory address width ({row[3:0], col[3:0]} for a 16x16 maze).
- DATA_W, 1, memory word width.
- LOCK_MAX, 4, maximum consecutive locked grants to one port while the other port is requesting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  per-port request; held high until that port's ack.
- we  in  2  per-port write enable (1 = write, 0 = read); sampled with req.
- lock  in  2  per-port lock: keep the grant after the current ack.
- addr0, addr1  in  ADDR_W  per-port address.
- wdata0, wdata1  in  DATA_W  per-port write data.
- ack  out  2  one-cycle per-port completion pulse.
- rdata  out  DATA_W  read data; valid only while the matching ack bit is high.
- gnt  out  2  one-hot current owner; 0 when idle.
- busy  out  1  high in any state other than ARB.
- mem_cen, mem_wr, mem_rd  out  1  memory chip enable, write strobe and read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data, valid 1 cycle after the mem_rd cycle.

Behaviour:
- States: ARB, ACCESS, RDATA.
- Reset (rst = 0, asynchronous):
  - State goes to ARB.
  - All outputs are 0.
  - last_gnt = 1, so port 0 wins the first contest.
  - lock_cnt = 0 and owner = none.
  - Any in-flight transaction is abandoned with no ack.
- ARB:
  - If no req is high, stay in ARB.
  - Otherwise choose a winner and register owner, we, addr and wdata from the winning port; next state is ACCESS.
- Winner selection, in order:
  1. Lock hold: the previous owner had lock = 1 at its ack, its req is still high, and lock_cnt < LOCK_MAX → the previous owner wins.
  2. Only one port requesting → that port wins.
  3. Both requesting → the port != last_gnt wins.
- lock_cnt update:
  - Increments on each lock-hold grant made while the other port is requesting.
  - Clears on any non-lock grant.
  - Clears when the other port is not requesting, so the cap only limits starvation.
- ACCESS (1 cycle):
  - mem_cen = 1, mem_addr and mem_din come from the registered values, gnt = one-hot owner.
  - Write: mem_wr = 1, ack[owner] = 1 in this same cycle, then → ARB.
  - Read: mem_rd = 1, then → RDATA.
- RDATA (1 cycle): rdata = mem_dout, ack[owner] = 1, mem_cen = 0, then → ARB.
- last_gnt is updated to the owner at every ack.
- Latency, from the edge at which ARB samples req:
  - Write: ack is high during the 1st following cycle.
  - Read: ack is high during the 2nd following cycle.
  - Minimum back-to-back spacing: 2 cycles per write, 3 per read.
- Outputs ack, gnt, busy and the mem_* signals are Moore outputs of the registered state and transaction registers. No combinational path from req to the memory pins.
- Requester rules:
  - addr, we and wdata must be stable from req rise until ack.
  - After ack, the requester deasserts req on the following edge, or keeps it high to issue a new transaction with new operands.
  - Dropping req before ack is illegal; the arbiter still completes the transaction and pulses ack.
- The non-owning port's ack is always 0.
- mem_wr and mem_rd are never high together; neither is ever high without mem_cen.
- Simultaneous req rise on both ports in ARB → resolved by last_gnt with no lost request: the loser keeps req high and is granted next.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds outputs gcnt0 and gcnt1, 16 bits each: per-port count of completed transactions (incremented at ack, saturating at 16'hFFFF, cleared by rst).
  - Adds input stat_clr: synchronous clear of both counters. stat_clr takes priority over an increment in the same cycle.
- When not defined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset then single read: req = 2'b01, we0 = 0, addr0 = 8'h23, memory[8'h23] = 1 → ARB, ACCESS (mem_rd = 1, mem_addr = 8'h23), RDATA (ack = 2'b01, rdata = 1); busy high for 2 cycles.
- Single write: req = 2'b10, we1 = 1, addr1 = 8'h5A, wdata1 = 1 → next cycle mem_cen = mem_wr = 1, mem_addr = 8'h5A, ack = 2'b10; readback of 8'h5A returns 1.
- Contention from reset: req = 2'b11 in the same cycle, both reads → port 0 acked first, port 1 acked 3 cycles later; continuous 2'b11 alternates 0, 1, 0, 1.
- Lock: port 0 holds lock = 1 and req = 1 with 6 back-to-back writes while port 1 requests continuously, LOCK_MAX = 4 → port 0 granted 5 times (1 plain + 4 lock-hold), then port 1, then port 0.
- Reset mid-read: assert rst = 0 during RDATA → ack stays 0, all outputs 0 immediately; after release, a pending req is served normally.
- ARB_STATS_EN: 3 port-0 and 2 port-1 transactions → gcnt0 = 3, gcnt1 = 2; stat_clr pulse → both 0.
